// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and helpers (receiver FSM states, baud divisor)
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction
endpackage

// File: rtl/uart_sync.sv
// uart_sync: N-flop synchronizer for an asynchronous pin
// ports: clk, rst (sync active-high), d (async in), q (synchronized out)
module uart_sync #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [N-1:0] ff;
    always_ff @(posedge clk)
        ff <= rst ? {N{RST_VAL}} : {ff[N-2:0], d};
    assign q = ff[N-1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 UART receiver with one-deep valid/ready output register
// ports: clk, rst (sync active-high), rx_sig (async serial in),
//        data_to_host/valid_to_host/ready_from_host (host handshake),
//        frame_err, overrun (one-cycle error pulses)
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 115200,
    parameter int CLK_FREQ   = 100_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_sig,
    output logic [DATA_WIDTH-1:0] data_to_host,
    output logic                  valid_to_host,
    input  logic                  ready_from_host,
    output logic                  frame_err,
    output logic                  overrun
);
    import uart_pkg::*;
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int IW           = $clog2(DATA_WIDTH + 1);
    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_rate
            $error("uart_rx: CLKS_PER_BIT must be at least 4");
        end
    endgenerate
    logic                  rx_s, rx_d;
    uart_rx_state_t        state;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] sr;
    logic                  bit_end;
    uart_sync #(.N(2), .RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(rx_sig), .q(rx_s));
    assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_d          <= 1'b1;
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            sr            <= '0;
            data_to_host  <= '0;
            valid_to_host <= 1'b0;
            frame_err     <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            rx_d      <= rx_s;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (valid_to_host && ready_from_host)
                valid_to_host <= 1'b0;
            case (state)
                IDLE: begin
                    // cnt starts at 1 so the start sample lands HALF_BIT-1 after the edge clock
                    cnt <= '0;
                    if (rx_d && !rx_s) begin
                        state <= START;
                        cnt   <= CW'(1);
                    end
                end
                START: begin
                    if (cnt == CW'(HALF_BIT - 1)) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else
                        cnt <= cnt + 1'b1;
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        sr  <= {rx_s, sr[DATA_WIDTH-1:1]};
                        idx <= idx + 1'b1;
                        if (idx == IW'(DATA_WIDTH - 1))
                            state <= STOP;
                    end else
                        cnt <= cnt + 1'b1;
                end
                STOP: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (!rx_s)
                            frame_err <= 1'b1;
                        else if (!valid_to_host || ready_from_host) begin
                            data_to_host  <= sr;
                            valid_to_host <= 1'b1;
                        end else
                            overrun <= 1'b1;
                    end else
                        cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx with a behavioural line driver
module tb_uart_rx;
    localparam int CLK_FREQ = 25_600_000;
    localparam int BAUD     = 100_000;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int HALF     = CPB / 2;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_sig = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid, frame_err, overrun;
    int         cyc = 0;
    int         errors = 0, checks = 0;
    logic [7:0] got[$];
    int         fe_cnt = 0, ov_cnt = 0, wide_cnt = 0, valid_rise = -1, v_hi = 0;
    logic       fe_p = 1'b0, ov_p = 1'b0, v_p = 1'b0;

    uart_rx #(.DATA_WIDTH(8), .BAUD_RATE(BAUD), .CLK_FREQ(CLK_FREQ)) dut (
        .clk(clk), .rst(rst), .rx_sig(rx_sig), .data_to_host(data), .valid_to_host(valid),
        .ready_from_host(ready), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // host-side observer: transfers, error pulses and their widths
    always @(negedge clk) begin
        if (valid && ready) got.push_back(data);
        if (frame_err && !fe_p) fe_cnt++;
        if (overrun && !ov_p) ov_cnt++;
        if ((frame_err && fe_p) || (overrun && ov_p)) wide_cnt++;
        if (valid && !v_p) valid_rise = cyc;
        if (valid) v_hi++;
        fe_p = frame_err;
        ov_p = overrun;
        v_p  = valid;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b, input int n = CPB);
        rx_sig = b;
        tick(n);
    endtask

    task automatic idle(input int bits);
        drive_bit(1'b1, bits * CPB);
    endtask

    // reference transmitter: start, 8 data bits LSB first, stop
    task automatic send_frame(input logic [7:0] b, input logic stop = 1'b1);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", valid); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%0b exp=0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
    endtask

    task automatic test_idle;
        int fe0, ov0, v0;
        fe0 = fe_cnt; ov0 = ov_cnt; v0 = v_hi;
        got.delete();
        ready = 1'b1;
        idle(50);
        checks++; if (v_hi != v0 || got.size() != 0) begin errors++; $display("FAIL idle_valid got=%0d exp=0", v_hi - v0); end
        checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL idle_frame_err got=%0d exp=0", fe_cnt - fe0); end
        checks++; if (ov_cnt != ov0) begin errors++; $display("FAIL idle_overrun got=%0d exp=0", ov_cnt - ov0); end
    endtask

    task automatic test_single;
        int start, v0, fe0;
        ready = 1'b1;
        got.delete();
        v0 = v_hi; fe0 = fe_cnt;
        start = cyc;
        send_frame(8'hC3);
        idle(1);
        checks++; if (got.size() != 1 || got[0] !== 8'hC3) begin errors++; $display("FAIL single_data got=%p exp=C3", got); end
        checks++; if (valid_rise != start + HALF + 2 + 9 * CPB) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", valid_rise - start, HALF + 2 + 9 * CPB); end
        checks++; if (v_hi - v0 != 1) begin errors++; $display("FAIL single_valid_width got=%0d exp=1", v_hi - v0); end
        checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL single_frame_err got=%0d exp=0", fe_cnt - fe0); end
    endtask

    task automatic test_stall;
        int ov0;
        ready = 1'b0;
        got.delete();
        send_frame(8'hB3);
        idle(1);
        checks++; if (valid !== 1'b1 || data !== 8'hB3) begin errors++; $display("FAIL stall_hold got=%0b/%h exp=1/b3", valid, data); end
        ov0 = ov_cnt;
        send_frame(8'h5A);
        idle(1);
        checks++; if (ov_cnt != ov0 + 1) begin errors++; $display("FAIL stall_overrun got=%0d exp=1", ov_cnt - ov0); end
        checks++; if (valid !== 1'b1 || data !== 8'hB3) begin errors++; $display("FAIL stall_keep got=%0b/%h exp=1/b3", valid, data); end
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL stall_release got=%0b exp=0", valid); end
        checks++; if (got.size() != 1 || got[0] !== 8'hB3) begin errors++; $display("FAIL stall_transfer got=%p exp=b3", got); end
        checks++; if (wide_cnt != 0) begin errors++; $display("FAIL pulse_width got=%0d exp=0", wide_cnt); end
    endtask

    task automatic test_glitch_framing;
        int fe0;
        ready = 1'b1;
        got.delete();
        fe0 = fe_cnt;
        drive_bit(1'b0, 100);
        idle(2);
        checks++; if (got.size() != 0 || fe_cnt != fe0) begin errors++; $display("FAIL glitch got=%0d/%0d exp=0/0", got.size(), fe_cnt - fe0); end
        send_frame(8'h3C);
        idle(1);
        checks++; if (got.size() != 1 || got[0] !== 8'h3C) begin errors++; $display("FAIL after_glitch got=%p exp=3c", got); end
        got.delete();
        send_frame(8'h00, 1'b0);
        idle(2);
        checks++; if (fe_cnt != fe0 + 1) begin errors++; $display("FAIL framing_err got=%0d exp=1", fe_cnt - fe0); end
        checks++; if (got.size() != 0 || valid !== 1'b0) begin errors++; $display("FAIL framing_no_valid got=%0d exp=0", got.size()); end
    endtask

    task automatic test_reset_mid;
        int fe0, ov0;
        ready = 1'b0;
        send_frame(8'h6E);
        idle(1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0, HALF);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++; if (valid !== 1'b0 || data !== 8'h00) begin errors++; $display("FAIL midrst_out got=%0b/%h exp=0/00", valid, data); end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL midrst_err got=%0b/%0b exp=0/0", frame_err, overrun); end
        ready = 1'b1;
        got.delete();
        fe0 = fe_cnt; ov0 = ov_cnt;
        idle(12);
        send_frame(8'h81);
        idle(1);
        checks++; if (got.size() != 1 || got[0] !== 8'h81) begin errors++; $display("FAIL midrst_next got=%p exp=81", got); end
        checks++; if (fe_cnt != fe0 || ov_cnt != ov0) begin errors++; $display("FAIL midrst_errors got=%0d/%0d exp=0/0", fe_cnt - fe0, ov_cnt - ov0); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp[$];
        int fe0, ov0;
        ready = 1'b1;
        got.delete();
        fe0 = fe_cnt; ov0 = ov_cnt;
        exp = '{8'h01, 8'h80};
        foreach (exp[i]) send_frame(exp[i]);
        idle(1);
        checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++; if (i >= got.size() || got[i] !== exp[i]) begin errors++; $display("FAIL b2b_data[%0d] got=%p exp=%h", i, got, exp[i]); end
        end
        checks++; if (fe_cnt != fe0 || ov_cnt != ov0) begin errors++; $display("FAIL b2b_errors got=%0d/%0d exp=0/0", fe_cnt - fe0, ov_cnt - ov0); end
    endtask

    task automatic test_loopback;
        logic [7:0] exp[$];
        ready = 1'b1;
        got.delete();
        exp = '{8'h00, 8'hFF, 8'hA5};
        foreach (exp[i]) begin
            send_frame(exp[i]);
            idle(1);
        end
        checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL loop_count got=%0d exp=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++; if (i >= got.size() || got[i] !== exp[i]) begin errors++; $display("FAIL loop_data[%0d] got=%p exp=%h", i, got, exp[i]); end
        end
    endtask

    task automatic test_random;
        logic [7:0] exp[$];
        logic [7:0] b;
        logic       stop;
        int         fe_exp, fe0, ov0, gap;
        ready = 1'b1;
        got.delete();
        fe0 = fe_cnt; ov0 = ov_cnt; fe_exp = 0;
        for (int n = 0; n < 6; n++) begin
            b    = 8'($urandom);
            stop = $urandom_range(0, 3) != 0;
            // a low stop bit needs idle afterwards so the next start is a fresh falling edge
            gap  = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
            send_frame(b, stop);
            if (stop) exp.push_back(b); else fe_exp++;
            if (gap > 0) idle(gap);
        end
        idle(1);
        checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++; if (i >= got.size() || got[i] !== exp[i]) begin errors++; $display("FAIL rand_data[%0d] got=%p exp=%h", i, got, exp[i]); end
        end
        checks++; if (fe_cnt - fe0 != fe_exp) begin errors++; $display("FAIL rand_frame_err got=%0d exp=%0d", fe_cnt - fe0, fe_exp); end
        checks++; if (ov_cnt != ov0) begin errors++; $display("FAIL rand_overrun got=%0d exp=0", ov_cnt - ov0); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_stall();
        test_glitch_framing();
        test_reset_mid();
        test_back_to_back();
        test_loopback();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
